// File: rtl/matmul_loader_pkg.sv
// Shared constants and state encoding for the matmul operand loader.
// Memory map, matrix geometry and the loader FSM state type live here.
package matmul_pkg;

   localparam int ADDR_W         = 10;
   localparam int MAT_DIM        = 4;
   localparam int BYTES_PER_WORD = 4;

   localparam logic [ADDR_W-1:0] BASE_A = 10'h000;
   localparam logic [ADDR_W-1:0] BASE_B = 10'h100;
   localparam logic [ADDR_W-1:0] BASE_C = 10'h200;

   typedef enum logic [2:0] {
      ST_LOAD      = 3'd0,
      ST_KICK      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_READ_C    = 3'd4,
      ST_CAPTURE   = 3'd5,
      ST_OUTPUT    = 3'd6
   } state_t;

   // Word index 0..3 are A rows, 4..7 are B columns.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [2:0] w);
      logic [ADDR_W-1:0] off;
      off = {{(ADDR_W-2){1'b0}}, w[1:0]};
      return w[2] ? (BASE_B + off) : (BASE_A + off);
   endfunction

endpackage

// File: rtl/matmul_loader_if.sv
// Operand stream, operand memory, engine control and result stream bundle.
// The master modport is the loader side; slave is the environment side.
interface matmul_loader_if;
   import matmul_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [7:0]        s_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_raddr;
   logic [31:0]       mem_rdata;
   logic              mm_kick;
   logic              mm_ready;
   logic              r_valid;
   logic              r_ready;
   logic [31:0]       r_data;

   modport master (
      input  s_valid, s_data, mem_rdata, mm_ready, r_ready,
      output s_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
             mm_kick, r_valid, r_data
   );

   modport slave (
      output s_valid, s_data, mem_rdata, mm_ready, r_ready,
      input  s_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
             mm_kick, r_valid, r_data
   );

endinterface

// File: rtl/matmul_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words and strobes each
// completed word for exactly one cycle.
module byte_packer
   import matmul_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [BYTES_PER_WORD-1:0][7:0] r_shift;
   logic [BYTES_PER_WORD-1:0][7:0] w_next;
   logic [1:0]                     r_lane;
   logic [31:0]                    r_word;
   logic                           r_word_valid;

   always_comb begin
      w_next         = r_shift;
      w_next[r_lane] = i_byte;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_shift      <= '0;
         r_lane       <= 2'd0;
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_accept) begin
            r_shift <= w_next;
            r_lane  <= r_lane + 2'd1;
            // The last lane closes the word; the strobe lands next cycle.
            if (r_lane == 2'd3) begin
               r_word       <= w_next;
               r_word_valid <= 1'b1;
            end
         end
      end
   end

   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;

endmodule

// File: rtl/matmul_loader.sv
// Feeds A rows / B columns into operand memory, kicks the matmul engine and
// returns the pooled 2x2 result word on a valid/ready stream.
module matmul_loader
   import matmul_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   matmul_loader_if.master  bus
);

   state_t            r_state;
   state_t            w_next_state;
   logic [4:0]        r_byte_cnt;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_result;
   logic              w_s_ready;
   logic              w_accept;
   logic              w_kick;
   logic              w_re;
   logic [31:0]       w_word;
   logic              w_word_valid;

   assign w_s_ready = rstn && (r_state == ST_LOAD);
   assign w_accept  = bus.s_valid && w_s_ready;

   byte_packer u_packer (
      .clk          (clk),
      .rstn         (rstn),
      .i_accept     (w_accept),
      .i_byte       (bus.s_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= ST_LOAD;
         r_byte_cnt <= 5'd0;
         r_waddr    <= '0;
         r_result   <= 32'd0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 5'd1;
            // Address is latched alongside the packer's word so both appear
            // together with the registered write strobe.
            if (r_byte_cnt[1:0] == 2'd3)
               r_waddr <= word_addr(r_byte_cnt[4:2]);
         end
         if (r_state == ST_CAPTURE)
            r_result <= bus.mem_rdata;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_kick       = 1'b0;
      w_re         = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (w_accept && (r_byte_cnt == 5'd31))
               w_next_state = ST_KICK;
         end
         ST_KICK: begin
            if (bus.mm_ready) begin
               w_kick       = 1'b1;
               w_next_state = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            if (!bus.mm_ready)
               w_next_state = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (bus.mm_ready)
               w_next_state = ST_READ_C;
         end
         ST_READ_C: begin
            w_re         = 1'b1;
            w_next_state = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_next_state = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (bus.r_ready)
               w_next_state = ST_LOAD;
         end
         default: begin
            w_next_state = ST_LOAD;
         end
      endcase
   end

   assign bus.s_ready   = w_s_ready;
   assign bus.mem_we    = w_word_valid;
   assign bus.mem_waddr = r_waddr;
   assign bus.mem_wdata = w_word;
   assign bus.mem_re    = w_re;
   assign bus.mem_raddr = w_re ? BASE_C : '0;
   assign bus.mm_kick   = w_kick;
   assign bus.r_valid   = (r_state == ST_OUTPUT);
   assign bus.r_data    = r_result;

endmodule
